// File: rtl/pipe_reg_slice.sv
// Cascade of two-entry skid-buffer slices on a valid/ready stream.
// All readys and the output side come straight from flops.
module pipe_reg_slice #(
   parameter  int p_width  = 32,
   parameter  int p_stages = 2,
   localparam int p_cnt_w  = $clog2(2*p_stages+1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [p_width-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [p_width-1:0] o_data,
   output logic [p_cnt_w-1:0] o_count
);

   logic [p_stages-1:0] main_v_q, main_v_d;
   logic [p_stages-1:0] skid_v_q, skid_v_d;
   logic [p_width-1:0]  main_q [p_stages];
   logic [p_width-1:0]  main_d [p_stages];
   logic [p_width-1:0]  skid_q [p_stages];
   logic [p_width-1:0]  skid_d [p_stages];

   logic [p_stages-1:0] up_v;
   logic [p_stages-1:0] dn_rdy;
   logic [p_width-1:0]  up_d [p_stages];

   logic [p_cnt_w-1:0]  cnt_q, cnt_d;
   logic                in_xfer;
   logic                out_xfer;

   // Slice k is fed by slice k-1's main entry; its ready is k+1's skid-free flag
   always_comb begin
      up_v   = '0;
      dn_rdy = '0;
      for (int k = 0; k < p_stages; k++) begin
         up_d[k] = '0;
      end
      up_v[0]            = i_valid;
      up_d[0]            = i_data;
      dn_rdy[p_stages-1] = i_ready;
      for (int k = 1; k < p_stages; k++) begin
         up_v[k]     = main_v_q[k-1];
         up_d[k]     = main_q[k-1];
         dn_rdy[k-1] = ~skid_v_q[k];
      end
   end

   always_comb begin
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      for (int k = 0; k < p_stages; k++) begin
         main_d[k] = main_q[k];
         skid_d[k] = skid_q[k];
      end
      for (int k = 0; k < p_stages; k++) begin
         if (skid_v_q[k]) begin
            if (dn_rdy[k]) begin
               main_d[k]   = skid_q[k];
               skid_v_d[k] = 1'b0;
            end
         end else if (up_v[k]) begin
            if (main_v_q[k] && !dn_rdy[k]) begin
               skid_d[k]   = up_d[k];
               skid_v_d[k] = 1'b1;
            end else begin
               main_d[k]   = up_d[k];
               main_v_d[k] = 1'b1;
            end
         end else if (dn_rdy[k]) begin
            main_v_d[k] = 1'b0;
         end
      end
      // Flush drops occupancy only; payload registers keep stale data
      if (i_flush) begin
         main_v_d = '0;
         skid_v_d = '0;
      end
   end

   assign in_xfer  = i_valid & ~skid_v_q[0];
   assign out_xfer = main_v_q[p_stages-1] & i_ready;

   always_comb begin
      cnt_d = cnt_q;
      if (i_flush) begin
         cnt_d = '0;
      end else if (in_xfer && !out_xfer) begin
         cnt_d = cnt_q + p_cnt_w'(1);
      end else if (!in_xfer && out_xfer) begin
         cnt_d = cnt_q - p_cnt_w'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         main_v_q <= '0;
         skid_v_q <= '0;
         cnt_q    <= '0;
         for (int k = 0; k < p_stages; k++) begin
            main_q[k] <= '0;
            skid_q[k] <= '0;
         end
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         cnt_q    <= cnt_d;
         for (int k = 0; k < p_stages; k++) begin
            main_q[k] <= main_d[k];
            skid_q[k] <= skid_d[k];
         end
      end
   end

   assign o_ready = ~skid_v_q[0];
   assign o_valid = main_v_q[p_stages-1];
   assign o_data  = main_q[p_stages-1];
   assign o_count = cnt_q;

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Bench for pipe_reg_slice: directed scenarios plus random traffic,
// checked by an ordered-queue scoreboard of accepted items.
module tb_pipe_reg_slice;

   localparam int W  = 8;
   localparam int S  = 3;
   localparam int CW = $clog2(2*S+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_v = 1'b0;
   logic          o_rdy;
   logic [W-1:0]  in_d = '0;
   logic          o_v;
   logic          dn_rdy = 1'b0;
   logic [W-1:0]  o_d;
   logic [CW-1:0] o_cnt;

   pipe_reg_slice #(.p_width(W), .p_stages(S)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_flush(flush),
      .i_valid(in_v),
      .o_ready(o_rdy),
      .i_data (in_d),
      .o_valid(o_v),
      .i_ready(dn_rdy),
      .o_data (o_d),
      .o_count(o_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      int           c;
   } ent_t;

   ent_t         q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   bit           armed = 0;
   bit           stall_q = 0;
   logic [W-1:0] stall_d = '0;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: state checks, then pop on output, push on input
   always @(negedge clk) begin
      if (armed) begin
         ent_t e;
         chk("count_vs_model", 32'(o_cnt), 32'(q.size()));
         if (q.size() == 2*S) chk("full_not_ready", 32'(o_rdy), 0);
         if (q.size() == 0) begin
            chk("empty_not_valid", 32'(o_v), 0);
            chk("empty_ready", 32'(o_rdy), 1);
         end
         if (stall_q) begin
            chk("stall_valid", 32'(o_v), 1);
            chk("stall_data", 32'(o_d), 32'(stall_d));
         end
         if (rst || flush) begin
            q.delete();
         end else begin
            if (o_v && dn_rdy) begin
               if (q.size() == 0) begin
                  chk("unexpected_output", 32'(o_d), 32'hDEAD);
               end else begin
                  e = q.pop_front();
                  chk("out_data", 32'(o_d), 32'(e.d));
                  chk("min_latency", 32'(cyc - e.c >= S), 1);
               end
            end
            if (in_v && o_rdy) q.push_back('{in_d, cyc});
         end
         stall_q = o_v && !dn_rdy && !rst && !flush;
         stall_d = o_d;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      logic [W-1:0] nxt;

      // Reset held two cycles with random inputs
      for (int i = 0; i < 2; i++) begin
         rst    = 1'b1;
         flush  = 1'($urandom);
         in_v   = 1'($urandom);
         dn_rdy = 1'($urandom);
         in_d   = W'($urandom);
         step();
         armed = 1;
      end
      rst = 0; flush = 0; in_v = 0; dn_rdy = 0;
      chk("rst_valid", 32'(o_v), 0);
      chk("rst_ready", 32'(o_rdy), 1);
      chk("rst_count", 32'(o_cnt), 0);
      chk("rst_data", 32'(o_d), 0);

      // Latency: single item through an empty pipe
      dn_rdy = 1;
      for (int c = 0; c <= 4; c++) begin
         in_v = (c == 0);
         in_d = 8'hA5;
         chk("lat_valid", 32'(o_v), 32'(c == S));
         if (c == S) chk("lat_data", 32'(o_d), 32'hA5);
         chk("lat_count", 32'(o_cnt), 32'(c >= 1 && c <= S));
         step();
      end
      in_v = 0;

      // Fill under backpressure, then drain in order
      dn_rdy = 0;
      acc = 0;
      nxt = 8'h01;
      for (int c = 0; c < 16; c++) begin
         in_v = 1;
         in_d = nxt;
         if (o_rdy) begin
            acc++;
            nxt++;
         end
         step();
      end
      in_v = 0;
      chk("fill_accepted", 32'(acc), 2*S);
      chk("fill_ready", 32'(o_rdy), 0);
      chk("fill_count", 32'(o_cnt), 2*S);
      dn_rdy = 1;
      for (int k = 0; k < 2*S; k++) begin
         chk("drain_valid", 32'(o_v), 1);
         chk("drain_data", 32'(o_d), 32'(k + 1));
         step();
      end
      chk("drain_empty", 32'(o_v), 0);

      // Throughput: 20 back-to-back items
      for (int c = 0; c < 25; c++) begin
         in_v = (c < 20);
         in_d = W'(8'h10 + c);
         chk("tp_valid", 32'(o_v), 32'(c >= S && c < 20 + S));
         if (c >= S && c < 20 + S)
            chk("tp_data", 32'(o_d), 32'(8'h10 + c - S));
         step();
      end
      in_v = 0;

      // Flush a full pipe while offering 0xFF
      dn_rdy = 0;
      for (int c = 0; c < 16; c++) begin
         in_v = 1;
         in_d = W'(8'h30 + c);
         step();
      end
      chk("pre_flush_count", 32'(o_cnt), 2*S);
      flush = 1; in_v = 1; in_d = 8'hFF; dn_rdy = 1;
      step();
      flush = 0; in_v = 0;
      chk("flush_count", 32'(o_cnt), 0);
      chk("flush_valid", 32'(o_v), 0);
      chk("flush_ready", 32'(o_rdy), 1);
      for (int c = 0; c < 6; c++) begin
         chk("flush_no_ff", 32'(o_v), 0);
         step();
      end

      // Reset with flush in the middle of traffic
      dn_rdy = 0;
      for (int c = 0; c < 10; c++) begin
         if (o_cnt == CW'(4)) break;
         in_v = 1;
         in_d = W'($urandom);
         step();
      end
      in_v = 0;
      chk("pre_rst_count", 32'(o_cnt), 4);
      rst = 1; flush = 1; in_v = 1; dn_rdy = 1; in_d = 8'h77;
      step();
      rst = 0; flush = 0; in_v = 0;
      chk("mrst_valid", 32'(o_v), 0);
      chk("mrst_ready", 32'(o_rdy), 1);
      chk("mrst_count", 32'(o_cnt), 0);
      chk("mrst_data", 32'(o_d), 0);

      // Random traffic with occasional flush and reset
      for (int c = 0; c < 600; c++) begin
         in_v   = ($urandom_range(0, 3) != 0);
         dn_rdy = ($urandom_range(0, 2) != 0);
         in_d   = W'($urandom);
         flush  = ($urandom_range(0, 39) == 0);
         rst    = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 0; flush = 0; in_v = 0; dn_rdy = 1;
      for (int c = 0; c < 20; c++) step();
      chk("final_drained", 32'(q.size()), 0);
      chk("final_count", 32'(o_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
